// File: rtl/lane_pkg.sv
// Shared types and default constants for the lane mover block.
package lane_pkg;

  typedef enum logic [1:0] {
    SPD_SLOW  = 2'd0,
    SPD_FAST  = 2'd1,
    SPD_TURBO = 2'd2
  } speed_t;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_t;

  localparam int unsigned DEF_X_W         = 10;
  localparam int unsigned DEF_OBJ_W       = 32;
  localparam int unsigned DEF_LEFT_BOUND  = 207;
  localparam int unsigned DEF_RIGHT_BOUND = 431;
  localparam int unsigned DEF_LANE_Y      = 298;
  localparam int unsigned DEF_DIV_SLOW    = 3000000;
  localparam int unsigned DEF_DIV_FAST    = 1000000;
  localparam int unsigned DEF_DIV_TURBO   = 500000;
  localparam int unsigned DEF_CNT_W       = 22;

endpackage

// File: rtl/lane_tick_gen.sv
// Step divider: raises tick on the cycle a step is due for the selected speed.
module lane_tick_gen
  import lane_pkg::*;
#(
  parameter int unsigned DIV_SLOW  = DEF_DIV_SLOW,
  parameter int unsigned DIV_FAST  = DEF_DIV_FAST,
  parameter int unsigned DIV_TURBO = DEF_DIV_TURBO,
  parameter int unsigned CNT_W     = DEF_CNT_W
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic       run,
  input  logic [1:0] speed,
  input  logic       clear,
  output logic       tick
);

  localparam logic [CNT_W-1:0] LIM_SLOW  = CNT_W'(DIV_SLOW - 1);
  localparam logic [CNT_W-1:0] LIM_FAST  = CNT_W'(DIV_FAST - 1);
  localparam logic [CNT_W-1:0] LIM_TURBO = CNT_W'(DIV_TURBO - 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] lim;

  // Terminal count for the current speed; the reserved code falls back to slow.
  always_comb begin
    lim = LIM_SLOW;
    case (speed)
      SPD_FAST:  lim = LIM_FAST;
      SPD_TURBO: lim = LIM_TURBO;
      default:   lim = LIM_SLOW;
    endcase
  end

  // >= rather than == so a lowered limit mid-count steps at once instead of overrunning.
  assign tick = run && (cnt >= lim);

  // Free-running divider that holds while the lane is frozen.
  always_ff @(posedge frame_clk) begin
    if (Reset || clear) begin
      cnt <= '0;
    end else if (run) begin
      if (tick) cnt <= '0;
      else      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/lane_mover.sv
// Moves N_OBJ objects along one horizontal lane with wrap-around at the bounds.
module lane_mover
  import lane_pkg::*;
#(
  parameter int unsigned N_OBJ       = 3,
  parameter int unsigned X_W         = DEF_X_W,
  parameter int unsigned OBJ_W       = DEF_OBJ_W,
  parameter int unsigned LEFT_BOUND  = DEF_LEFT_BOUND,
  parameter int unsigned RIGHT_BOUND = DEF_RIGHT_BOUND,
  parameter int unsigned LANE_Y      = DEF_LANE_Y,
  parameter dir_t        DIR         = DIR_LEFT,
  parameter int unsigned STEP_PX     = 1,
  parameter int unsigned DIV_SLOW    = DEF_DIV_SLOW,
  parameter int unsigned DIV_FAST    = DEF_DIV_FAST,
  parameter int unsigned DIV_TURBO   = DEF_DIV_TURBO,
  parameter int unsigned CNT_W       = DEF_CNT_W
) (
  input  logic                   frame_clk,
  input  logic                   Reset,
  input  logic [N_OBJ*X_W-1:0]   init_x,
  input  logic                   load,
  input  logic                   run,
  input  logic [1:0]             speed,
  output logic [N_OBJ*X_W-1:0]   obj_x,
  output logic [X_W-1:0]         obj_y,
  output logic                   step,
  output logic [N_OBJ-1:0]       wrap
);

  // Comparison operands carry one extra bit so x+OBJ_W and x-STEP_PX never alias.
  localparam logic [X_W:0]   LB_E   = (X_W+1)'(LEFT_BOUND);
  localparam logic [X_W:0]   RB_E   = (X_W+1)'(RIGHT_BOUND);
  localparam logic [X_W:0]   OW_E   = (X_W+1)'(OBJ_W);
  localparam logic [X_W:0]   SP_E   = (X_W+1)'(STEP_PX);
  localparam logic [X_W-1:0] RB_X   = X_W'(RIGHT_BOUND);
  localparam logic [X_W-1:0] WRAP_R = X_W'(LEFT_BOUND - OBJ_W);

  logic                 tick;
  logic [N_OBJ*X_W-1:0] x_next;
  logic [N_OBJ-1:0]     wrap_next;

  assign obj_y = X_W'(LANE_Y);

  lane_tick_gen #(
    .DIV_SLOW  (DIV_SLOW),
    .DIV_FAST  (DIV_FAST),
    .DIV_TURBO (DIV_TURBO),
    .CNT_W     (CNT_W)
  ) u_tick (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .run       (run),
    .speed     (speed),
    .clear     (load),
    .tick      (tick)
  );

  for (genvar gi = 0; gi < N_OBJ; gi++) begin : g_obj
    logic [X_W:0]   cur;
    logic [X_W-1:0] nx;
    logic           nw;

    assign cur = {1'b0, obj_x[gi*X_W +: X_W]};

    // Next position of this object and whether that move is a wrap.
    always_comb begin
      nw = 1'b0;
      nx = cur[X_W-1:0];
      if (DIR == DIR_LEFT) begin
        if ((cur + OW_E < LB_E) || (cur < SP_E)) begin
          nx = RB_X;
          nw = 1'b1;
        end else begin
          nx = X_W'(cur - SP_E);
        end
      end else begin
        if (cur > RB_E) begin
          nx = WRAP_R;
          nw = 1'b1;
        end else begin
          nx = X_W'(cur + SP_E);
        end
      end
    end

    assign x_next[gi*X_W +: X_W] = nx;
    assign wrap_next[gi]         = nw;
  end

  // Position registers plus step/wrap pulses; reset and load override a due step.
  always_ff @(posedge frame_clk) begin
    if (Reset || load) begin
      obj_x <= init_x;
      step  <= 1'b0;
      wrap  <= '0;
    end else if (tick) begin
      obj_x <= x_next;
      step  <= 1'b1;
      wrap  <= wrap_next;
    end else begin
      step  <= 1'b0;
      wrap  <= '0;
    end
  end

endmodule

// File: tb/tb_lane_mover.sv
// Directed bench for lane_mover: stepping, wraps, speed switch, freeze, load, reset.
module tb_lane_mover;
  import lane_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Instance A: left-moving, two objects, slow divider of 4.
  logic        a_reset, a_load, a_run, a_step;
  logic [1:0]  a_speed, a_wrap;
  logic [19:0] a_init, a_x;
  logic [9:0]  a_y;

  // Instance R: right-moving, two objects, slow divider of 4.
  logic        r_reset, r_load, r_run, r_step;
  logic [1:0]  r_speed, r_wrap;
  logic [19:0] r_init, r_x;
  logic [9:0]  r_y;

  // Instance S: one object, slow 8 / fast 2 / turbo 3.
  logic        s_reset, s_load, s_run, s_step;
  logic [1:0]  s_speed;
  logic [0:0]  s_wrap;
  logic [9:0]  s_init, s_x, s_y;

  lane_mover #(.N_OBJ(2), .DIV_SLOW(4), .DIV_FAST(2), .DIV_TURBO(3), .CNT_W(8)) u_a (
    .frame_clk(clk), .Reset(a_reset), .init_x(a_init), .load(a_load), .run(a_run),
    .speed(a_speed), .obj_x(a_x), .obj_y(a_y), .step(a_step), .wrap(a_wrap));

  lane_mover #(.N_OBJ(2), .DIR(DIR_RIGHT), .DIV_SLOW(4), .DIV_FAST(2), .DIV_TURBO(3), .CNT_W(8)) u_r (
    .frame_clk(clk), .Reset(r_reset), .init_x(r_init), .load(r_load), .run(r_run),
    .speed(r_speed), .obj_x(r_x), .obj_y(r_y), .step(r_step), .wrap(r_wrap));

  lane_mover #(.N_OBJ(1), .DIV_SLOW(8), .DIV_FAST(2), .DIV_TURBO(3), .CNT_W(8)) u_s (
    .frame_clk(clk), .Reset(s_reset), .init_x(s_init), .load(s_load), .run(s_run),
    .speed(s_speed), .obj_x(s_x), .obj_y(s_y), .step(s_step), .wrap(s_wrap));

  function automatic logic [19:0] pk2(input int unsigned x1, input int unsigned x0);
    return {x1[9:0], x0[9:0]};
  endfunction

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    a_reset = 1'b1; a_run = 1'b1; a_init = pk2(300, 250);
    r_reset = 1'b1; s_reset = 1'b1;
    cyc(2);
    n_chk++; if (a_x !== pk2(300, 250)) begin n_fail++; $display("FAIL reset_x got %h want %h", a_x, pk2(300, 250)); end
    n_chk++; if (a_step !== 1'b0) begin n_fail++; $display("FAIL reset_step got %b want 0", a_step); end
    n_chk++; if (a_wrap !== 2'b00) begin n_fail++; $display("FAIL reset_wrap got %b want 00", a_wrap); end
    n_chk++; if (a_y !== 10'd298) begin n_fail++; $display("FAIL reset_y got %0d want 298", a_y); end
    n_chk++; if (s_y !== 10'd298) begin n_fail++; $display("FAIL reset_y_s got %0d want 298", s_y); end
  endtask

  task automatic test_stepping();
    a_reset = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      cyc(1);
      n_chk++;
      if (a_step !== ((c % 4) == 0)) begin
        n_fail++; $display("FAIL step_period cycle %0d got %b want %b", c, a_step, ((c % 4) == 0));
      end
      if ((c % 4) == 0) begin
        n_chk++;
        if (a_x !== pk2(300 - c/4, 250 - c/4)) begin
          n_fail++; $display("FAIL step_pos cycle %0d got %h want %h", c, a_x, pk2(300 - c/4, 250 - c/4));
        end
      end
    end
    n_chk++; if (a_x !== pk2(297, 247)) begin n_fail++; $display("FAIL three_steps got %h want %h", a_x, pk2(297, 247)); end
  endtask

  task automatic test_left_wrap();
    a_reset = 1'b1; a_init = pk2(175, 174);
    cyc(1);
    a_reset = 1'b0;
    cyc(3);
    n_chk++; if (a_step !== 1'b0) begin n_fail++; $display("FAIL lwrap_early_step got %b want 0", a_step); end
    cyc(1);
    n_chk++; if (a_x !== pk2(174, 431)) begin n_fail++; $display("FAIL lwrap_x1 got %h want %h", a_x, pk2(174, 431)); end
    n_chk++; if (a_wrap !== 2'b01) begin n_fail++; $display("FAIL lwrap_w1 got %b want 01", a_wrap); end
    n_chk++; if (a_step !== 1'b1) begin n_fail++; $display("FAIL lwrap_step got %b want 1", a_step); end
    cyc(1);
    n_chk++; if (a_wrap !== 2'b00) begin n_fail++; $display("FAIL lwrap_pulse got %b want 00", a_wrap); end
    cyc(3);
    n_chk++; if (a_x !== pk2(431, 430)) begin n_fail++; $display("FAIL lwrap_x2 got %h want %h", a_x, pk2(431, 430)); end
    n_chk++; if (a_wrap !== 2'b10) begin n_fail++; $display("FAIL lwrap_w2 got %b want 10", a_wrap); end
  endtask

  task automatic test_freeze_load();
    a_load = 1'b1; a_init = pk2(300, 250);
    cyc(1);
    a_load = 1'b0;
    n_chk++; if (a_x !== pk2(300, 250)) begin n_fail++; $display("FAIL load_x got %h want %h", a_x, pk2(300, 250)); end
    cyc(2);
    a_run = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      cyc(1);
      n_chk++;
      if (a_step !== 1'b0 || a_x !== pk2(300, 250)) begin
        n_fail++; $display("FAIL freeze cycle %0d got step %b x %h want step 0 x %h", c, a_step, a_x, pk2(300, 250));
      end
    end
    a_run = 1'b1;
    cyc(1);
    n_chk++; if (a_step !== 1'b0) begin n_fail++; $display("FAIL resume_early got %b want 0", a_step); end
    cyc(1);
    n_chk++; if (a_step !== 1'b1 || a_x !== pk2(299, 249)) begin
      n_fail++; $display("FAIL resume_step got step %b x %h want step 1 x %h", a_step, a_x, pk2(299, 249));
    end
    cyc(3);
    a_load = 1'b1; a_init = pk2(100, 174);
    cyc(1);
    a_load = 1'b0;
    n_chk++; if (a_x !== pk2(100, 174)) begin n_fail++; $display("FAIL load_prio_x got %h want %h", a_x, pk2(100, 174)); end
    n_chk++; if (a_step !== 1'b0 || a_wrap !== 2'b00) begin
      n_fail++; $display("FAIL load_prio_pulse got step %b wrap %b want 0 00", a_step, a_wrap);
    end
    cyc(3);
    n_chk++; if (a_step !== 1'b0) begin n_fail++; $display("FAIL load_restart got %b want 0", a_step); end
    cyc(1);
    n_chk++; if (a_x !== pk2(431, 431) || a_wrap !== 2'b11) begin
      n_fail++; $display("FAIL dual_wrap got x %h wrap %b want x %h wrap 11", a_x, a_wrap, pk2(431, 431));
    end
  endtask

  task automatic test_reset_mid();
    a_load = 1'b1; a_init = pk2(300, 250);
    cyc(1);
    a_load = 1'b0;
    cyc(4);
    n_chk++; if (a_x !== pk2(299, 249)) begin n_fail++; $display("FAIL rmid_pre got %h want %h", a_x, pk2(299, 249)); end
    cyc(2);
    a_reset = 1'b1;
    cyc(1);
    a_reset = 1'b0;
    n_chk++; if (a_x !== pk2(300, 250) || a_step !== 1'b0) begin
      n_fail++; $display("FAIL rmid_x got x %h step %b want x %h step 0", a_x, a_step, pk2(300, 250));
    end
    for (int c = 1; c <= 4; c++) begin
      cyc(1);
      n_chk++;
      if (a_step !== (c == 4)) begin
        n_fail++; $display("FAIL rmid_step cycle %0d got %b want %b", c, a_step, (c == 4));
      end
    end
  endtask

  task automatic test_right();
    r_reset = 1'b1; r_run = 1'b1; r_init = pk2(431, 432);
    cyc(1);
    r_reset = 1'b0;
    cyc(4);
    n_chk++; if (r_x !== pk2(432, 175) || r_wrap !== 2'b01 || r_step !== 1'b1) begin
      n_fail++; $display("FAIL rwrap1 got x %h wrap %b step %b want x %h wrap 01 step 1", r_x, r_wrap, r_step, pk2(432, 175));
    end
    cyc(4);
    n_chk++; if (r_x !== pk2(175, 176) || r_wrap !== 2'b10) begin
      n_fail++; $display("FAIL rwrap2 got x %h wrap %b want x %h wrap 10", r_x, r_wrap, pk2(175, 176));
    end
  endtask

  task automatic test_speed_switch();
    s_reset = 1'b1; s_run = 1'b1; s_speed = 2'd0; s_init = 10'd300;
    cyc(1);
    s_reset = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      cyc(1);
      n_chk++; if (s_step !== 1'b0) begin n_fail++; $display("FAIL slow_early cycle %0d got %b want 0", c, s_step); end
    end
    s_speed = 2'd1;
    cyc(1);
    n_chk++; if (s_step !== 1'b1 || s_x !== 10'd299) begin
      n_fail++; $display("FAIL switch_step got step %b x %0d want step 1 x 299", s_step, s_x);
    end
    for (int c = 1; c <= 4; c++) begin
      cyc(1);
      n_chk++; if (s_step !== ((c % 2) == 0)) begin
        n_fail++; $display("FAIL fast_period cycle %0d got %b want %b", c, s_step, ((c % 2) == 0));
      end
    end
    n_chk++; if (s_x !== 10'd297) begin n_fail++; $display("FAIL fast_x got %0d want 297", s_x); end
    s_speed = 2'd3;
    for (int c = 1; c <= 8; c++) begin
      cyc(1);
      n_chk++; if (s_step !== (c == 8)) begin
        n_fail++; $display("FAIL reserved_period cycle %0d got %b want %b", c, s_step, (c == 8));
      end
    end
    s_speed = 2'd2;
    for (int c = 1; c <= 6; c++) begin
      cyc(1);
      n_chk++; if (s_step !== ((c % 3) == 0)) begin
        n_fail++; $display("FAIL turbo_period cycle %0d got %b want %b", c, s_step, ((c % 3) == 0));
      end
    end
    n_chk++; if (s_x !== 10'd294 || s_wrap !== 1'b0) begin
      n_fail++; $display("FAIL turbo_x got x %0d wrap %b want x 294 wrap 0", s_x, s_wrap);
    end
  endtask

  initial begin
    a_reset = 1'b1; a_load = 1'b0; a_run = 1'b0; a_speed = 2'd0; a_init = '0;
    r_reset = 1'b1; r_load = 1'b0; r_run = 1'b0; r_speed = 2'd0; r_init = '0;
    s_reset = 1'b1; s_load = 1'b0; s_run = 1'b0; s_speed = 2'd0; s_init = '0;
    test_reset();
    test_stepping();
    test_left_wrap();
    test_freeze_load();
    test_reset_mid();
    test_right();
    test_speed_switch();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
